// File: rtl/adc_stream_sched.sv
// adc_stream_sched: packs 14-bit ADC samples into 32-bit FIFO words, frames
// them behind a header word every FRAME_WORDS data words, and shares the
// single txfifo write port with a low-rate status-word requester.
// Optional build macro: ADC_STREAM_TSTAMP_EN adds a free-running sample
// counter and a second header word (HDR2) carrying the latched count.
module adc_stream_sched #(
    parameter int unsigned FRAME_WORDS = 256,
    parameter logic [15:0] HDR_MAGIC   = 16'hA55A
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic [13:0] adc_data,
    input  logic        adc_valid,
    input  logic        stream_en,
    input  logic        stat_req,
    input  logic [31:0] stat_word,
    output logic        stat_ack,
    input  logic        txfifo_full,
    output logic        txfifo_wr,
    output logic [31:0] txfifo_data,
    output logic [15:0] frame_seq,
    output logic [15:0] drop_cnt,
    output logic        streaming
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_HDR    = 2'd1;
    localparam logic [1:0]  ST_HDR2   = 2'd2;
    localparam logic [1:0]  ST_DATA   = 2'd3;
    localparam logic [15:0] LAST_WCNT = 16'(FRAME_WORDS - 1);

    function automatic logic [15:0] sext16(input logic [13:0] s);
        return {{2{s[13]}}, s};
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nx_s;
    logic        phase_r;
    logic [13:0] s0_r;
    logic [15:0] wcnt_r;
    logic [15:0] wcnt_nx_s;
    logic [15:0] frame_seq_r;
    logic [15:0] frame_seq_nx_s;
    logic [15:0] drop_cnt_r;
    logic        wr_r;
    logic        wr_nx_s;
    logic [31:0] data_r;
    logic [31:0] data_nx_s;
    logic        ack_r;
    logic        ack_nx_s;
    logic        streaming_r;
    logic        drop_s;
    logic        ts_latch_s;
    logic        word_rdy_s;
    logic [31:0] word_s;
    logic        stat_go_s;
    logic        last_s;
    logic [31:0] ts_word_s;

    assign word_rdy_s = (state_r != ST_IDLE) && adc_valid && phase_r;
    assign word_s     = {sext16(adc_data), sext16(s0_r)};
    // An ack already in flight blocks a second status write, so a requester
    // that drops stat_req one cycle after seeing stat_ack is not serviced twice.
    assign stat_go_s  = stat_req && !txfifo_full && !ack_r;
    assign last_s     = (wcnt_r == LAST_WCNT);

`ifdef ADC_STREAM_TSTAMP_EN
    logic [31:0] ts_cnt_r;
    logic [31:0] ts_lat_r;

    // Free-running sample counter, counting in every state, and its header latch.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            ts_cnt_r <= 32'd0;
            ts_lat_r <= 32'd0;
        end else begin
            if (adc_valid) begin
                ts_cnt_r <= ts_cnt_r + 32'd1;
            end
            if (ts_latch_s) begin
                ts_lat_r <= ts_cnt_r;
            end
        end
    end

    assign ts_word_s = ts_lat_r;
`else
    assign ts_word_s = 32'd0;
`endif

    // Write-port arbitration and framing state machine.
    always_comb begin
        state_nx_s     = state_r;
        wr_nx_s        = 1'b0;
        data_nx_s      = data_r;
        ack_nx_s       = 1'b0;
        frame_seq_nx_s = frame_seq_r;
        wcnt_nx_s      = wcnt_r;
        drop_s         = 1'b0;
        ts_latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stat_go_s) begin
                    wr_nx_s   = 1'b1;
                    data_nx_s = stat_word;
                    ack_nx_s  = 1'b1;
                end else if (stream_en) begin
                    state_nx_s = ST_HDR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (word_rdy_s) begin
                    drop_s = 1'b1;
                end else if (stat_go_s) begin
                    wr_nx_s   = 1'b1;
                    data_nx_s = stat_word;
                    ack_nx_s  = 1'b1;
                end else if (!txfifo_full) begin
                    wr_nx_s        = 1'b1;
                    data_nx_s      = {HDR_MAGIC, frame_seq_r};
                    frame_seq_nx_s = frame_seq_r + 16'd1;
                    wcnt_nx_s      = 16'd0;
                    ts_latch_s     = 1'b1;
`ifdef ADC_STREAM_TSTAMP_EN
                    state_nx_s     = ST_HDR2;
`else
                    state_nx_s     = ST_DATA;
`endif
                end else begin
                    state_nx_s = ST_HDR;
                end
            end
`ifdef ADC_STREAM_TSTAMP_EN
            ST_HDR2: begin
                if (word_rdy_s) begin
                    drop_s = 1'b1;
                end else if (!txfifo_full) begin
                    wr_nx_s    = 1'b1;
                    data_nx_s  = ts_word_s;
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_HDR2;
                end
            end
`endif
            ST_DATA: begin
                if (word_rdy_s) begin
                    if (!txfifo_full) begin
                        wr_nx_s   = 1'b1;
                        data_nx_s = word_s;
                    end else begin
                        drop_s = 1'b1;
                    end
                    // Dropped words still occupy a slot so frame timing holds.
                    wcnt_nx_s = wcnt_r + 16'd1;
                    if (last_s) begin
                        state_nx_s = stream_en ? ST_HDR : ST_IDLE;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, framing counters and registered write-port outputs.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_r     <= ST_IDLE;
            wcnt_r      <= 16'd0;
            frame_seq_r <= 16'd0;
            wr_r        <= 1'b0;
            data_r      <= 32'd0;
            ack_r       <= 1'b0;
            streaming_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            wcnt_r      <= wcnt_nx_s;
            frame_seq_r <= frame_seq_nx_s;
            wr_r        <= wr_nx_s;
            data_r      <= data_nx_s;
            ack_r       <= ack_nx_s;
            streaming_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Saturating drop counter; only reset clears it.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    // Sample packer: pairs samples while streaming, held clear in IDLE.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            phase_r <= 1'b0;
            s0_r    <= 14'd0;
        end else if (state_r == ST_IDLE) begin
            phase_r <= 1'b0;
            s0_r    <= 14'd0;
        end else if (adc_valid) begin
            if (!phase_r) begin
                s0_r <= adc_data;
            end
            phase_r <= ~phase_r;
        end
    end

    assign txfifo_wr   = wr_r;
    assign txfifo_data = data_r;
    assign stat_ack    = ack_r;
    assign frame_seq   = frame_seq_r;
    assign drop_cnt    = drop_cnt_r;
    assign streaming   = streaming_r;

endmodule

// File: tb/tb_adc_stream_sched.sv
// Self-checking bench for adc_stream_sched with FRAME_WORDS=4.
// Expected FIFO words are queued as stimulus is planned and compared by a
// monitor whenever the DUT strobes txfifo_wr.
module tb_adc_stream_sched;

    logic        adc_clk;
    logic        adc_rst;
    logic [13:0] adc_data;
    logic        adc_valid;
    logic        stream_en;
    logic        stat_req;
    logic [31:0] stat_word;
    logic        stat_ack;
    logic        txfifo_full;
    logic        txfifo_wr;
    logic [31:0] txfifo_data;
    logic [15:0] frame_seq;
    logic [15:0] drop_cnt;
    logic        streaming;

    int checks = 0;
    int errors = 0;
    int acks   = 0;
    logic [31:0] exp_q[$];

    adc_stream_sched #(.FRAME_WORDS(4), .HDR_MAGIC(16'hA55A)) dut (
        .adc_clk     (adc_clk),
        .adc_rst     (adc_rst),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .stream_en   (stream_en),
        .stat_req    (stat_req),
        .stat_word   (stat_word),
        .stat_ack    (stat_ack),
        .txfifo_full (txfifo_full),
        .txfifo_wr   (txfifo_wr),
        .txfifo_data (txfifo_data),
        .frame_seq   (frame_seq),
        .drop_cnt    (drop_cnt),
        .streaming   (streaming)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    function automatic logic [31:0] hdr(input logic [15:0] seq);
        return {16'hA55A, seq};
    endfunction

    // Expected data word: first sample (lo) in the low half, both sign-extended.
    function automatic logic [31:0] pw(input logic [13:0] lo, input logic [13:0] hi);
        return {{2{hi[13]}}, hi, {2{lo[13]}}, lo};
    endfunction

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge adc_clk) begin
        if (!adc_rst && txfifo_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %08h expected none", txfifo_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (txfifo_data !== e) begin
                    errors++;
                    $display("FAIL write_data got %08h expected %08h", txfifo_data, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge adc_clk);
        if (stat_ack) begin
            acks++;
            stat_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge adc_clk);
        adc_rst     = 1'b1;
        adc_valid   = 1'b0;
        adc_data    = 14'd0;
        stream_en   = 1'b0;
        stat_req    = 1'b0;
        txfifo_full = 1'b0;
        @(negedge adc_clk);
        @(negedge adc_clk);
        exp_q.delete();
        acks    = 0;
        adc_rst = 1'b0;
        @(negedge adc_clk);
    endtask

    // Stream samples 1..nsamp; stream_en drops from sample en_off on,
    // full is asserted on sample full_at, stat_req rises on sample req_at.
    task automatic stream_run(input int nsamp, input int en_off, input int full_at, input int req_at);
        stream_en = 1'b1;
        adc_valid = 1'b0;
        step();
        for (int i = 1; i <= nsamp; i++) begin
            adc_data    = 14'(i);
            adc_valid   = 1'b1;
            stream_en   = (i < en_off);
            txfifo_full = (i == full_at);
            if (i == req_at) begin
                stat_req = 1'b1;
            end
            step();
        end
        adc_valid   = 1'b0;
        txfifo_full = 1'b0;
        stream_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge adc_clk);
        adc_rst = 1'b1;
        @(negedge adc_clk);
        checks++;
        if ({txfifo_wr, stat_ack, streaming} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {txfifo_wr, stat_ack, streaming});
        end
        checks++;
        if (txfifo_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %08h expected 00000000", txfifo_data);
        end
        checks++;
        if ({frame_seq, drop_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got %08h expected 00000000", {frame_seq, drop_cnt});
        end
        adc_rst = 1'b0;
        @(negedge adc_clk);
    endtask

    task automatic test_basic();
        do_reset();
        exp_q.push_back(hdr(16'd0));
        for (int i = 1; i < 9; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        exp_q.push_back(hdr(16'd1));
        for (int i = 9; i < 17; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_run(16, 16, 0, 0);
        drain("basic");
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_drop_cnt got %0d expected 0", drop_cnt);
        end
        checks++;
        if (frame_seq !== 16'd2 || streaming !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got seq=%0d streaming=%b expected seq=2 streaming=0", frame_seq, streaming);
        end
    endtask

    task automatic test_sign();
        logic [13:0] smp[8];
        smp = '{14'h2000, 14'h1FFF, 14'h3FFF, 14'h0000, 14'd5, 14'd6, 14'd7, 14'd8};
        do_reset();
        exp_q.push_back(hdr(16'd0));
        exp_q.push_back(32'h1FFFE000);
        exp_q.push_back(32'h0000FFFF);
        exp_q.push_back(32'h00060005);
        exp_q.push_back(32'h00080007);
        stream_en = 1'b1;
        adc_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            adc_data  = smp[i];
            adc_valid = 1'b1;
            stream_en = (i < 7);
            step();
        end
        adc_valid = 1'b0;
        stream_en = 1'b0;
        drain("sign");
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_q.push_back(hdr(16'd0));
        exp_q.push_back(pw(14'd1, 14'd2));
        exp_q.push_back(pw(14'd5, 14'd6));
        exp_q.push_back(pw(14'd7, 14'd8));
        exp_q.push_back(hdr(16'd1));
        for (int i = 9; i < 17; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_run(16, 16, 4, 0);
        drain("backpressure");
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL backpressure_drop_cnt got %0d expected 1", drop_cnt);
        end
    endtask

    task automatic test_status_boundary();
        do_reset();
        stat_word = 32'hDEADBEEF;
        exp_q.push_back(hdr(16'd0));
        for (int i = 1; i < 9; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(hdr(16'd1));
        for (int i = 11; i < 19; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_run(18, 18, 0, 8);
        drain("status_boundary");
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL status_ack_count got %0d expected 1", acks);
        end
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL status_drop_cnt got %0d expected 1", drop_cnt);
        end
    endtask

    task automatic test_status_idle();
        do_reset();
        stat_word = 32'h12345678;
        exp_q.push_back(32'h12345678);
        stat_req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        drain("status_idle");
        checks++;
        if (acks != 1 || streaming !== 1'b0) begin
            errors++;
            $display("FAIL status_idle got acks=%0d streaming=%b expected acks=1 streaming=0", acks, streaming);
        end
    endtask

    task automatic test_stop();
        do_reset();
        exp_q.push_back(hdr(16'd0));
        for (int i = 1; i < 9; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_run(12, 5, 0, 0);
        drain("stop");
        checks++;
        if (streaming !== 1'b0 || frame_seq !== 16'd1) begin
            errors++;
            $display("FAIL stop_idle got streaming=%b seq=%0d expected streaming=0 seq=1", streaming, frame_seq);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        exp_q.push_back(hdr(16'd0));
        exp_q.push_back(pw(14'd1, 14'd2));
        exp_q.push_back(pw(14'd3, 14'd4));
        exp_q.push_back(pw(14'd5, 14'd6));
        stream_en = 1'b1;
        adc_valid = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) begin
            adc_data  = 14'(i);
            adc_valid = 1'b1;
            step();
        end
        checks++;
        if (txfifo_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre_wr got %b expected 1", txfifo_wr);
        end
        #2;
        adc_rst = 1'b1;
        #1;
        checks++;
        if (txfifo_wr !== 1'b0 || frame_seq !== 16'd0 || streaming !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got wr=%b seq=%0d streaming=%b expected 0 0 0", txfifo_wr, frame_seq, streaming);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_pending got %0d expected 0", exp_q.size());
        end
        exp_q.delete();
        adc_valid = 1'b0;
        stream_en = 1'b0;
        @(negedge adc_clk);
        adc_rst = 1'b0;
        @(negedge adc_clk);
        exp_q.push_back(hdr(16'd0));
        for (int i = 1; i < 9; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_run(8, 8, 0, 0);
        drain("rst_mid_restart");
    endtask

`ifdef ADC_STREAM_TSTAMP_EN
    task automatic test_tstamp();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            adc_data  = 14'(i);
            adc_valid = 1'b1;
            step();
        end
        exp_q.push_back(hdr(16'd0));
        exp_q.push_back(32'h0000000A);
        for (int i = 1; i < 9; i += 2) exp_q.push_back(pw(14'(i), 14'(i + 1)));
        stream_en = 1'b1;
        adc_valid = 1'b0;
        step();
        step();
        step();
        for (int i = 1; i <= 8; i++) begin
            adc_data  = 14'(i);
            adc_valid = 1'b1;
            stream_en = (i < 8);
            step();
        end
        adc_valid = 1'b0;
        stream_en = 1'b0;
        drain("tstamp");
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tstamp_drop_cnt got %0d expected 0", drop_cnt);
        end
    endtask
`endif

    initial begin
        adc_rst     = 1'b1;
        adc_data    = 14'd0;
        adc_valid   = 1'b0;
        stream_en   = 1'b0;
        stat_req    = 1'b0;
        stat_word   = 32'd0;
        txfifo_full = 1'b0;
        test_reset();
`ifdef ADC_STREAM_TSTAMP_EN
        test_tstamp();
`else
        test_basic();
        test_sign();
        test_backpressure();
        test_status_boundary();
        test_status_idle();
        test_stop();
        test_rst_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_stream_sched.md
Name: adc_stream_sched

Overview:
- Sequences the 14-bit ADC sample stream into 32-bit words for the FT601 TX FIFO write port.
- Inserts a framing header every FRAME_WORDS data words.
- Shares the single write port with a low-rate status-word requester.
- Sits in the adc_clk domain, between the ADC capture and the proto245s txfifo_* interface.

Parameters:
- FRAME_WORDS, 256, data words per frame; legal range 2..65535.
- HDR_MAGIC, 16'hA55A, upper half of the header word.

Ports:
- adc_clk  in  1  sample clock; the only clock.
- adc_rst  in  1  asynchronous, active-high reset.
- adc_data  in  14  two's-complement ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- stream_en  in  1  level; request streaming.
- stat_req  in  1  level; status word pending; held until stat_ack.
- stat_word  in  32  status payload; stable while stat_req is high.
- stat_ack  out  1  one-cycle pulse when stat_word is written.
- txfifo_full  in  1  FIFO cannot accept a write this cycle.
- txfifo_wr  out  1  write strobe; never high while txfifo_full.
- txfifo_data  out  32  write data.
- frame_seq  out  16  sequence number of the next header.
- drop_cnt  out  16  saturating count of dropped data words.
- streaming  out  1  high when state is not IDLE.

Behaviour:
- Reset values: txfifo_wr=0, txfifo_data=0, stat_ack=0, frame_seq=0, drop_cnt=0, streaming=0, state=IDLE, packer phase=0, wcnt=0.
- Registered outputs: txfifo_wr, txfifo_data and stat_ack are registered. All decisions use the current-cycle txfifo_full; a write is issued one cycle after its decision, and the FIFO is assumed to absorb that one-cycle skew.
- Packer operation:
  - Active only when state is not IDLE.
  - On adc_valid with phase=0: latch s0 and set phase=1.
  - On adc_valid with phase=1: complete word = {sext16(s1), sext16(s0)} with s0 in the low half ("word_rdy"), then clear phase=0.
- State IDLE:
  - Packer phase is held at 0; samples are ignored and not counted.
  - If stat_req and !full: write stat_word, pulse stat_ack.
  - Else if stream_en: go to HDR.
- State HDR:
  - If word_rdy: that word is dropped and drop_cnt increments; no other write happens this cycle.
  - Else if stat_req and !full: write stat_word, pulse stat_ack, stay in HDR.
  - Else if !full: write {HDR_MAGIC, frame_seq}, increment frame_seq (wraps at 16 bits), set wcnt=0, go to DATA.
  - Else: stall in HDR.
- State DATA:
  - On word_rdy with !full: write the word.
  - On word_rdy with full: drop the word and increment drop_cnt.
  - Either way wcnt increments, so frame timing is preserved and the host detects loss from the header sequence.
  - When the FRAME_WORDS-th word is written or dropped: go to HDR if stream_en is high, else go to IDLE.
- Packer continuity: the packer is not cleared on the DATA to HDR transition. At one sample per cycle, a header fits the free phase with no loss. A status word inserted at a boundary costs one pair, counted in drop_cnt.
- stream_en deassert: ignored mid-frame; the current frame always completes.
- Entering IDLE: clears phase and discards any held half-sample.
- drop_cnt: saturates at 16'hFFFF and is cleared only by reset.
- Status arbitration: status never preempts a data word. It is serviced only in IDLE or HDR, ahead of the next header.
- adc_rst mid-frame: all state returns to reset values immediately. The next stream begins with a header carrying frame_seq=0.

Optional Feature:
- Macro: ADC_STREAM_TSTAMP_EN.
- With the macro defined:
  - A free-running 32-bit sample counter increments on every adc_valid, including in IDLE; it is reset to 0 and wraps.
  - The counter value is latched when the header is written.
  - A state HDR2 follows HDR and writes the latched count as a second header word, subject to the same full-stall and word_rdy-drop rules, then goes to DATA.
  - wcnt excludes both header words.
- Without the macro: no counter and no HDR2; the header is one word.

Test Plan:
- Setup for all scenarios unless stated: FRAME_WORDS=4, adc_valid=1 every cycle, samples 1,2,3,…, full=0.
- Basic framing: stream_en=1 -> writes A55A0000, 00020001, 00040003, 00060005, 00080007, then A55A0001. drop_cnt=0 throughout.
- Sign extension: samples 14'h2000, 14'h1FFF -> data word 1FFFE000.
- Backpressure: full=1 for exactly one word_rdy in DATA -> that word is not written, drop_cnt=1, the frame still has 4 word slots, and the next header is A55A0001.
- Status at boundary: stat_req=1 with stat_word=DEADBEEF during the last data word -> DEADBEEF is written in HDR before A55A0001, stat_ack pulses once, drop_cnt=1.
- Stop and reset:
  - Drop stream_en after word 2 -> words 3 and 4 are still written, then IDLE with streaming=0.
  - Assert adc_rst mid-frame -> txfifo_wr=0 and frame_seq=0 immediately.
- Timestamp (with ADC_STREAM_TSTAMP_EN), stall in IDLE: hold stream_en=0 for 10 valid samples, then stream -> A55A0000 followed by 0000000A.
